// File: rtl/ram_32to256_sdp_if.sv
// Bus bundle for the asymmetric 32-bit-write / 256-bit-read simple dual-port RAM.
// The writer drives the wr_* and rd_addr signals. The RAM returns rd_data.
`timescale 1ns/1ps
interface ram_32to256_sdp_if #(
    parameter int unsigned WR_DW = 32,
    parameter int unsigned WR_AW = 11,
    parameter int unsigned RD_DW = 256,
    parameter int unsigned RD_AW = 8
);
    logic             wr_en;
    logic [WR_AW-1:0] wr_addr;
    logic [WR_DW-1:0] wr_data;
    logic [RD_AW-1:0] rd_addr;
    logic [RD_DW-1:0] rd_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data
    );
endinterface

// File: rtl/ram_32to256_sdp.sv
// 64 Kbit dual-clock RAM: 32-bit writes on udp_clk, full 256-bit row reads on rd_clk.
// Storage is 8 lanes x 256 rows. Write word 8k+i lands in lane i of row k.
`timescale 1ns/1ps
module ram_32to256_sdp #(
    parameter int unsigned WR_DW = 32,
    parameter int unsigned WR_AW = 11,
    parameter int unsigned RD_DW = 256,
    parameter int unsigned RD_AW = 8
) (
    input  logic              udp_clk,
    input  logic              rd_clk,
    input  logic              rstn,
    ram_32to256_sdp_if.slave  bus
);
    localparam int unsigned LANES  = RD_DW / WR_DW;
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned ROWS   = 2 ** RD_AW;

    logic [WR_DW-1:0]  mem [LANES][ROWS];
    logic [LANE_W-1:0] wr_lane;
    logic [RD_AW-1:0]  wr_row;

    assign wr_lane = bus.wr_addr[LANE_W-1:0];
    assign wr_row  = bus.wr_addr[WR_AW-1:LANE_W];

    // Contents survive reset; rstn only blocks the write strobe.
    always_ff @(posedge udp_clk) begin
        if (rstn && bus.wr_en) begin
            mem[wr_lane][wr_row] <= bus.wr_data;
        end
    end

    always_ff @(posedge rd_clk or negedge rstn) begin
        if (!rstn) begin
            bus.rd_data <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                bus.rd_data[i*WR_DW +: WR_DW] <= mem[i][bus.rd_addr];
            end
        end
    end
endmodule

// File: tb/tb_ram_32to256_sdp.sv
// Bench for ram_32to256_sdp: table-driven row reads checked through a scoreboard queue,
// plus hand-written reset, write-gating and full-memory streaming sequences.
`timescale 1ns/1ps
module tb_ram_32to256_sdp;
    logic udp_clk = 1'b0;
    logic rd_clk  = 1'b0;
    logic rstn    = 1'b0;

    always #4     udp_clk = ~udp_clk;   // 125 MHz
    always #6.734 rd_clk  = ~rd_clk;    // ~74.25 MHz

    ram_32to256_sdp_if bus ();

    ram_32to256_sdp dut (
        .udp_clk (udp_clk),
        .rd_clk  (rd_clk),
        .rstn    (rstn),
        .bus     (bus.slave)
    );

    typedef struct {
        logic        en;
        logic [10:0] addr;
        logic [31:0] data;
    } wr_vec_t;

    typedef struct {
        logic [7:0]   row;
        logic [255:0] exp;
    } rd_vec_t;

    typedef struct {
        string        name;
        logic [255:0] exp;
    } sb_entry_t;

    localparam logic [255:0] ROW0 = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
    localparam logic [255:0] ROW1 = 256'h01000007_01000006_01000005_01000004_01000003_01000002_01000001_01000000;
    localparam logic [255:0] ROW3 = 256'h30000007_30000006_30000005_30000004_30000003_30000002_30000001_30000000;
    localparam logic [255:0] ROW255 = 256'hDEADBEEF_A0000006_A0000005_A0000004_A0000003_A0000002_A0000001_A0000000;

    wr_vec_t   wr_tab[$];
    rd_vec_t   rd_tab[8];
    sb_entry_t sb[$];
    int        n_tests = 0;
    int        n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic en, input logic [10:0] addr, input logic [31:0] data);
        @(negedge udp_clk);
        bus.wr_en   = en;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(posedge udp_clk);
    endtask

    task automatic wr_idle();
        @(negedge udp_clk);
        bus.wr_en = 1'b0;
    endtask

    // Drive an address one half-cycle before the sampling edge, then pop the scoreboard.
    task automatic rd(input logic [7:0] row, input string name, input logic [255:0] exp);
        sb_entry_t e;
        @(negedge rd_clk);
        bus.rd_addr = row;
        sb.push_back('{name: name, exp: exp});
        @(posedge rd_clk);
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check(e.name, bus.rd_data, e.exp);
        end
    endtask

    task automatic settle_rd();
        repeat (2) @(posedge rd_clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] exp_row;

        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;

        // Write stimulus table
        for (int i = 0; i < 8; i++) wr_tab.push_back('{1'b1, 11'(i), 32'h1111_1111 * (i + 1)});
        for (int i = 0; i < 8; i++) wr_tab.push_back('{1'b1, 11'(8 + i), 32'h0100_0000 + i});
        for (int i = 0; i < 8; i++) wr_tab.push_back('{1'b1, 11'(24 + i), 32'h3000_0000 + i});
        for (int i = 0; i < 8; i++) wr_tab.push_back('{1'b0, 11'(24 + i), 32'hFFFF_0000 + i});
        wr_tab.push_back('{1'b1, 11'd2047, 32'h1234_5678});
        for (int i = 0; i < 7; i++) wr_tab.push_back('{1'b1, 11'(2040 + i), 32'hA000_0000 + i});
        wr_tab.push_back('{1'b1, 11'd2047, 32'hDEAD_BEEF});

        // Read table: consecutive entries are issued on back-to-back rd_clk cycles
        rd_tab[0] = '{8'd0,   ROW0};
        rd_tab[1] = '{8'd255, ROW255};
        rd_tab[2] = '{8'd3,   ROW3};
        rd_tab[3] = '{8'd1,   ROW1};
        rd_tab[4] = '{8'd0,   ROW0};
        rd_tab[5] = '{8'd1,   ROW1};
        rd_tab[6] = '{8'd255, ROW255};
        rd_tab[7] = '{8'd0,   ROW0};

        #20;
        check("reset_rd_data", bus.rd_data, '0);
        @(negedge rd_clk);
        rstn = 1'b1;

        foreach (wr_tab[i]) wr(wr_tab[i].en, wr_tab[i].addr, wr_tab[i].data);
        wr_idle();
        settle_rd();

        for (int i = 0; i < 8; i++) begin
            rd(rd_tab[i].row, $sformatf("table_row%0d_idx%0d", rd_tab[i].row, i), rd_tab[i].exp);
        end

        // Asynchronous reset mid-cycle with nonzero rd_data; a write during reset must be lost
        @(posedge rd_clk);
        #3;
        rstn = 1'b0;
        #1;
        check("reset_async_clear", bus.rd_data, '0);
        wr(1'b1, 11'd0, 32'hBAD0_BAD0);
        wr_idle();
        @(posedge rd_clk);
        #1;
        check("reset_hold_zero", bus.rd_data, '0);
        @(negedge rd_clk);
        rstn = 1'b1;
        rd(8'd0, "post_reset_row0", ROW0);

        // Full-memory stream of incrementing words, then sweep every row
        for (int i = 0; i < 2048; i++) wr(1'b1, 11'(i), 32'(i));
        wr_idle();
        settle_rd();
        for (int k = 0; k < 256; k++) begin
            for (int j = 0; j < 8; j++) exp_row[32*j +: 32] = 32'(8 * k + j);
            rd(8'(k), $sformatf("stream_row%0d", k), exp_row);
        end

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
